// File: rtl/rptr_empty_level_if.sv
// Read-side FIFO bundle: pop request, synchronised write pointer and the
// read-domain pointer/status outputs. slave = pointer block, master = user.
interface rptr_empty_level_if #(
  parameter int ADDR_W = 4
);
  logic              rpop;
  logic [ADDR_W:0]   wptr_rclk;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rlevel;
  logic              underflow;

  modport master (
    output rpop, wptr_rclk,
    input  raddr, rptr, empty, almost_empty, rlevel, underflow
  );

  modport slave (
    input  rpop, wptr_rclk,
    output raddr, rptr, empty, almost_empty, rlevel, underflow
  );
endinterface

// File: rtl/rptr_empty_level.sv
// Read-domain pointer, empty/almost-empty and fill level for the async FIFO.
// Optional sticky underflow detector built when AFIFO_UNDERFLOW_DETECT_EN is defined.
module rptr_empty_level #(
  parameter int ADDR_W   = 4,
  parameter int AE_LEVEL = 1
) (
  input  logic              rclk,
  input  logic              rrst,
  rptr_empty_level_if.slave rif
);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_LEVEL);

  logic [ADDR_W:0] rbin, rptr, rbinnext, rgraynext;
  logic [ADDR_W:0] wbin, lvl_next, rlevel_q;
  logic            empty_q, ae_q, pop_ok;

  assign pop_ok    = rif.rpop & ~empty_q;
  assign rbinnext  = rbin + {{ADDR_W{1'b0}}, pop_ok};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;

  // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_W; i++)
      wbin[i] = ^(rif.wptr_rclk >> i);
  end

  // Modular difference never exceeds 2**ADDR_W while pointers stay legal.
  assign lvl_next = wbin - rbinnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      rlevel_q <= '0;
    end else begin
      rbin     <= rbinnext;
      rptr     <= rgraynext;
      empty_q  <= (rgraynext == rif.wptr_rclk);
      ae_q     <= (lvl_next <= AE_LVL);
      rlevel_q <= lvl_next;
    end
  end

`ifdef AFIFO_UNDERFLOW_DETECT_EN
  logic uf_q;
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)                      uf_q <= 1'b0;
    else if (rif.rpop && empty_q)  uf_q <= 1'b1;
  end
  assign rif.underflow = uf_q;
`else
  assign rif.underflow = 1'b0;
`endif

  assign rif.raddr        = rbin[ADDR_W-1:0];
  assign rif.rptr         = rptr;
  assign rif.empty        = empty_q;
  assign rif.almost_empty = ae_q;
  assign rif.rlevel       = rlevel_q;
endmodule

// File: tb/tb_rptr_empty_level.sv
// Directed bench for rptr_empty_level, ADDR_W=2, AE_LEVEL=1.
module tb_rptr_empty_level;
  localparam int ADDR_W = 2;
`ifdef AFIFO_UNDERFLOW_DETECT_EN
  localparam logic UF_EXP = 1'b1;
`else
  localparam logic UF_EXP = 1'b0;
`endif

  logic rclk, rrst;
  int   cmps, errs;

  rptr_empty_level_if #(.ADDR_W(ADDR_W)) rif ();

  rptr_empty_level #(.ADDR_W(ADDR_W), .AE_LEVEL(1)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rif  (rif.slave)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [2:0] g3(input int x);
    return 3'(x ^ (x >> 1));
  endfunction

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  // {raddr, rptr, rlevel, empty, almost_empty, underflow}
  task automatic test_reset();
    logic [10:0] obs;
    rrst = 1'b1; rif.rpop = 1'b0; rif.wptr_rclk = '0;
    #3;
    obs = {rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow};
    cmps++;
    if (obs !== {2'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL reset_async obs=%b exp=%b", obs, {2'd0, 3'd0, 3'd0, 3'b110});
      errs++;
    end
    step(); step();
    rrst = 1'b0;
    step();
    obs = {rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow};
    cmps++;
    if (obs !== {2'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL reset_release obs=%b exp=%b", obs, {2'd0, 3'd0, 3'd0, 3'b110});
      errs++;
    end
  endtask

  task automatic test_fill();
    rif.wptr_rclk = 3'b010;
    step();
    cmps++;
    if ({rif.rlevel, rif.empty, rif.almost_empty} !== {3'd3, 1'b0, 1'b0}) begin
      $display("FAIL fill rlevel=%0d empty=%b ae=%b exp rlevel=3 empty=0 ae=0",
               rif.rlevel, rif.empty, rif.almost_empty);
      errs++;
    end
  endtask

  task automatic test_drain();
    logic [1:0] e_addr [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [2:0] e_ptr  [4] = '{3'b001, 3'b011, 3'b010, 3'b010};
    logic [2:0] e_lvl  [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
    logic       e_emp  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_ae   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       e_uf   [4] = '{1'b0, 1'b0, 1'b0, UF_EXP};
    rif.rpop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      cmps++;
      if ({rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow} !==
          {e_addr[k], e_ptr[k], e_lvl[k], e_emp[k], e_ae[k], e_uf[k]}) begin
        $display("FAIL drain_%0d raddr=%0d rptr=%b lvl=%0d empty=%b ae=%b uf=%b exp raddr=%0d rptr=%b lvl=%0d empty=%b ae=%b uf=%b",
                 k, rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow,
                 e_addr[k], e_ptr[k], e_lvl[k], e_emp[k], e_ae[k], e_uf[k]);
        errs++;
      end
    end
    rif.rpop = 1'b0;
  endtask

  task automatic test_wrap();
    int         rb = 3, wb = 3;
    logic [2:0] prev;
    logic       saw_wrap = 1'b0;
    for (int n = 0; n < 20; n++) begin
      wb = (wb + 1) % 8;
      rif.wptr_rclk = g3(wb);
      step();
      cmps++;
      if ({rif.rlevel, rif.empty, rif.rptr} !== {3'd1, 1'b0, g3(rb)}) begin
        $display("FAIL wrap_write_%0d lvl=%0d empty=%b rptr=%b exp lvl=1 empty=0 rptr=%b",
                 n, rif.rlevel, rif.empty, rif.rptr, g3(rb));
        errs++;
      end
      prev = rif.rptr;
      rif.rpop = 1'b1;
      step();
      rif.rpop = 1'b0;
      rb = (rb + 1) % 8;
      if (prev == 3'b100 && rif.rptr == 3'b000) saw_wrap = 1'b1;
      cmps++;
      if (rif.rptr !== g3(rb) || $countones(prev ^ rif.rptr) != 1 ||
          rif.raddr !== 2'(rb) || rif.rlevel > 3'd4 || rif.rlevel !== 3'd0 || rif.empty !== 1'b1) begin
        $display("FAIL wrap_pop_%0d rptr=%b prev=%b raddr=%0d lvl=%0d empty=%b exp rptr=%b raddr=%0d lvl=0 empty=1",
                 n, rif.rptr, prev, rif.raddr, rif.rlevel, rif.empty, g3(rb), 2'(rb));
        errs++;
      end
    end
    cmps++;
    if (saw_wrap !== 1'b1) begin
      $display("FAIL wrap_seen saw=%b exp=1", saw_wrap);
      errs++;
    end
  endtask

  task automatic test_full_simul();
    // asynchronous mid-cycle reset, also clears a sticky underflow
    #2;
    rrst = 1'b1; rif.wptr_rclk = '0;
    #1;
    cmps++;
    if ({rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow} !==
        {2'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL reset_mid raddr=%0d rptr=%b lvl=%0d empty=%b ae=%b uf=%b exp 0 000 0 1 1 0",
               rif.raddr, rif.rptr, rif.rlevel, rif.empty, rif.almost_empty, rif.underflow);
      errs++;
    end
    step();
    rrst = 1'b0;
    rif.wptr_rclk = 3'b110;
    step();
    cmps++;
    if ({rif.rlevel, rif.empty, rif.almost_empty} !== {3'd4, 1'b0, 1'b0}) begin
      $display("FAIL full lvl=%0d empty=%b ae=%b exp lvl=4 empty=0 ae=0",
               rif.rlevel, rif.empty, rif.almost_empty);
      errs++;
    end
    rif.rpop = 1'b1; rif.wptr_rclk = 3'b111;
    step();
    rif.rpop = 1'b0;
    cmps++;
    if ({rif.rlevel, rif.empty, rif.raddr, rif.rptr} !== {3'd4, 1'b0, 2'd1, 3'b001}) begin
      $display("FAIL simul lvl=%0d empty=%b raddr=%0d rptr=%b exp lvl=4 empty=0 raddr=1 rptr=001",
               rif.rlevel, rif.empty, rif.raddr, rif.rptr);
      errs++;
    end
  endtask

  task automatic test_underflow();
    #2;
    rrst = 1'b1; rif.wptr_rclk = '0;
    step();
    rrst = 1'b0;
    rif.rpop = 1'b1;
    step();
    rif.rpop = 1'b0;
    cmps++;
    if ({rif.underflow, rif.raddr, rif.rptr} !== {UF_EXP, 2'd0, 3'd0}) begin
      $display("FAIL uf_set uf=%b raddr=%0d rptr=%b exp uf=%b raddr=0 rptr=000",
               rif.underflow, rif.raddr, rif.rptr, UF_EXP);
      errs++;
    end
    rif.wptr_rclk = 3'b001;
    step();
    cmps++;
    if ({rif.underflow, rif.rlevel, rif.empty} !== {UF_EXP, 3'd1, 1'b0}) begin
      $display("FAIL uf_sticky uf=%b lvl=%0d empty=%b exp uf=%b lvl=1 empty=0",
               rif.underflow, rif.rlevel, rif.empty, UF_EXP);
      errs++;
    end
    #2;
    rrst = 1'b1;
    #1;
    cmps++;
    if (rif.underflow !== 1'b0) begin
      $display("FAIL uf_clear uf=%b exp=0", rif.underflow);
      errs++;
    end
    step();
    rrst = 1'b0;
  endtask

  initial begin
    cmps = 0; errs = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_full_simul();
    test_underflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule

// File: doc/rptr_empty_level.md
# rptr_empty_level

Read-domain pointer, empty and occupancy logic for the parametrised asynchronous FIFO. It replaces the fixed-width read-pointer/empty block. It adds configurable address width, a registered read-side fill level, an almost-empty threshold flag and an optional sticky underflow detector. It sits in the read clock domain, takes the two-flop-synchronised Gray write pointer, and drives the dual-port RAM read address plus the Gray read pointer exported to the write domain.

## Interface
- ADDR_W, 4: RAM address width; FIFO depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL; legal range 0..2**ADDR_W-1.

Ports:
- rclk  in  1  read clock.
- rrst  in  1  reset; asynchronous, active-high.
- rpop  in  1  read request; honoured only when empty=0.
- wptr_rclk  in  ADDR_W+1  Gray write pointer, already synchronised to rclk.
- raddr  out  ADDR_W  binary RAM read address.
- rptr  out  ADDR_W+1  registered Gray read pointer, to the write-domain synchroniser.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered, level <= AE_LEVEL.
- rlevel  out  ADDR_W+1  registered entries available, 0..2**ADDR_W.
- underflow  out  1  sticky pop-while-empty error; tied 0 when the feature is compiled out.

## Operation
- Internal registers: rbin and rptr, both ADDR_W+1 bits.
- Accept condition: pop_ok = rpop & ~empty. Next binary pointer: rbinnext = rbin + pop_ok, modulo 2**(ADDR_W+1).
- Next Gray pointer: rgraynext = (rbinnext >> 1) ^ rbinnext.
- On every rclk edge: rbin <= rbinnext and rptr <= rgraynext.
- raddr = rbin[ADDR_W-1:0], combinational from the register. It always addresses the current head entry.
- wbin = Gray-to-binary(wptr_rclk), combinational, ADDR_W+1 bits. Bit i = XOR of wptr_rclk[ADDR_W:i].
- lvl_next = (wbin - rbinnext) mod 2**(ADDR_W+1). This is the unsigned wrap-safe difference, which never exceeds 2**ADDR_W.
- Registered flags:
  - empty <= (rgraynext == wptr_rclk)
  - rlevel <= lvl_next
  - almost_empty <= (lvl_next <= AE_LEVEL)
- empty and (rlevel == 0) are always consistent in the same cycle.
- Pop while empty: the pointer does not move, and no RAM address changes.
- Pointer wrap: wrapping from 2**(ADDR_W+1)-1 to 0 is seamless. Gray successive values differ in exactly one bit.
- Flags are pessimistic by design. A write becomes visible only after synchroniser latency plus one register stage. A pop takes effect on the flags in the same edge that moves the pointer.

## Timing
- Reset values (asynchronous on rrst):
  - rbin = 0, rptr = 0, raddr = 0, rlevel = 0
  - empty = 1, almost_empty = 1, underflow = 0
- Pop latency: if rpop=1 and empty=0 at edge N, then raddr, rptr, rlevel and the flags reflect the pop after edge N.
- Popping the last entry: empty rises after the same edge N, with no bubble.
- Write visibility: a wptr_rclk change sampled at edge N updates empty, rlevel and almost_empty after edge N.
- Simultaneous pop and wptr_rclk advance in one cycle: the level is unchanged net, and empty stays 0.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for an rclk edge. Release is synchronous to rclk via the existing reset synchroniser.

## Configuration
- Macro: AFIFO_UNDERFLOW_DETECT_EN.
- Defined:
  - underflow is a register set to 1 on any edge where rpop=1 and empty=1.
  - It stays set until rrst.
- Undefined:
  - No register is built, and underflow is driven constant 0.
  - Port list is identical in both builds.

## Test plan
- Reset release, ADDR_W=2, AE_LEVEL=1, wptr_rclk=0 -> empty=1, almost_empty=1, rlevel=0, raddr=0, rptr=0, underflow=0.
- Fill: drive wptr_rclk to Gray(3)=3'b010, no pop -> one edge later rlevel=3, empty=0, almost_empty=0.
- Drain from rlevel=3, rpop held 1:
  - raddr steps 1, 2, 3.
  - rlevel steps 2, 1, 0.
  - almost_empty rises when rlevel=1.
  - empty rises after the third pop.
  - Further pops leave raddr=3 and rptr=Gray(3).
- Wrap: run 20 write/pop pairs with wptr_rclk a Gray count -> rptr passes 3'b100 -> 3'b000 cleanly, with exactly one bit changing per step; rlevel never exceeds 4.
- Full plus simultaneous events: wptr_rclk=Gray(4) with rbin=0 gives rlevel=4. Then pop at the same edge that wptr advances -> rlevel stays 4, empty=0.
- Underflow with AFIFO_UNDERFLOW_DETECT_EN defined: rpop=1 while empty=1 -> underflow=1 next edge and stays 1 after data arrives; rrst clears it. With the macro undefined, underflow stays 0 throughout.
